bucket_timer: RTL and testbench

Multi-channel programmable period timer that drives bucket rotation in the Bloom-filter aging logic. Each channel counts clock cycles up to a run-time-programmable period, then raises a held update request to its Bloom-filter bank. Once the bank acknowledges, the channel advances its current-bucket index modulo the bucket count. Missed periods, where a new period expires while a request is still unacknowledged, are flagged per channel.

---
 rtl/bucket_timer_pkg.sv | 11 +
 rtl/bucket_timer_chan.sv | 122 ++++++++++++
 rtl/bucket_timer.sv | 57 +++++
 tb/tb_bucket_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bucket_timer_pkg.sv
// Shared types and constants for the bucket rotation timer.
package bucket_timer_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StReq
   } chan_state_e;

   localparam int unsigned MISSED_CNT_WIDTH = 8;

endpackage

// File: rtl/bucket_timer_chan.sv
// One timer channel: period counter, request FSM, bucket index and overrun tracking.
// Optional missed-period counter enabled by BUCKET_TIMER_MISSED_CNT_EN.
module bucket_timer_chan
   import bucket_timer_pkg::*;
#(
   parameter int unsigned                PERIOD_WIDTH   = 32,
   parameter logic [PERIOD_WIDTH-1:0]    DEFAULT_PERIOD = '1,
   parameter int unsigned                NUM_BUCKETS    = 8,
   parameter int unsigned                BUCKET_BITS    = $clog2(NUM_BUCKETS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    cfg_we,
   input  logic [PERIOD_WIDTH-1:0] cfg_period,
   input  logic                    update_ack,
   input  logic                    overrun_clr,
   output logic                    update_req,
   output logic [BUCKET_BITS-1:0]  bucket_idx,
`ifdef BUCKET_TIMER_MISSED_CNT_EN
   output logic [MISSED_CNT_WIDTH-1:0] missed_cnt,
`endif
   output logic                    overrun
);

   chan_state_e             state_q, state_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic                    term_q, term_d;
   logic [BUCKET_BITS-1:0]  bucket_q, bucket_d;
   logic                    overrun_q, overrun_d;
   logic                    advance, drop;

`ifdef BUCKET_TIMER_MISSED_CNT_EN
   logic [MISSED_CNT_WIDTH-1:0] missed_q, missed_d;
`endif

   // Terminal is registered so the request rises P+1 edges after a write.
   always_comb begin
      period_d = cfg_we ? cfg_period : period_q;
      cnt_d    = '0;
      term_d   = 1'b0;
      if (!cfg_we && enable && (period_q != '0)) begin
         if (cnt_q == period_q - 1'b1) begin
            term_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         period_q  <= DEFAULT_PERIOD;
         cnt_q     <= '0;
         term_q    <= 1'b0;
         bucket_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         cnt_q     <= cnt_d;
         term_q    <= term_d;
         bucket_q  <= bucket_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (term_q) state_d = StReq;
         StReq:   if (update_ack && !term_q) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      advance   = (state_q == StReq) && update_ack;
      drop      = (state_q == StReq) && !update_ack && term_q;
      bucket_d  = bucket_q;
      if (advance) begin
         bucket_d = (bucket_q == BUCKET_BITS'(NUM_BUCKETS - 1)) ? '0 : bucket_q + 1'b1;
      end
      overrun_d = overrun_q;
      if (drop) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
      update_req = (state_q == StReq);
      bucket_idx = bucket_q;
      overrun    = overrun_q;
   end

`ifdef BUCKET_TIMER_MISSED_CNT_EN
   // An increment coinciding with a clear restarts the count at one.
   always_comb begin
      missed_d = missed_q;
      if (drop) begin
         if (overrun_clr) begin
            missed_d = MISSED_CNT_WIDTH'(1);
         end else if (missed_q != '1) begin
            missed_d = missed_q + 1'b1;
         end
      end else if (overrun_clr) begin
         missed_d = '0;
      end
      missed_cnt = missed_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         missed_q <= '0;
      end else begin
         missed_q <= missed_d;
      end
   end
`endif

endmodule

// File: rtl/bucket_timer.sv
// Multi-channel period timer driving Bloom-filter bucket rotation.
// Define BUCKET_TIMER_MISSED_CNT_EN to add per-channel saturating missed-period counters.
module bucket_timer
   import bucket_timer_pkg::*;
#(
   parameter int unsigned             NUM_CHANNELS   = 4,
   parameter int unsigned             PERIOD_WIDTH   = 32,
   parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = 'h3fff_ffff,
   parameter int unsigned             NUM_BUCKETS    = 8,
   localparam int unsigned            BUCKET_BITS    = $clog2(NUM_BUCKETS),
   localparam int unsigned            CHAN_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_CHANNELS-1:0]             chan_enable,
   input  logic                                cfg_wr,
   input  logic [CHAN_BITS-1:0]                cfg_chan,
   input  logic [PERIOD_WIDTH-1:0]             cfg_period,
   output logic [NUM_CHANNELS-1:0]             update_req,
   input  logic [NUM_CHANNELS-1:0]             update_ack,
   output logic [NUM_CHANNELS*BUCKET_BITS-1:0] bucket_idx,
   output logic [NUM_CHANNELS-1:0]             overrun,
`ifdef BUCKET_TIMER_MISSED_CNT_EN
   output logic [NUM_CHANNELS*MISSED_CNT_WIDTH-1:0] missed_cnt,
`endif
   input  logic [NUM_CHANNELS-1:0]             overrun_clr
);

   logic [NUM_CHANNELS-1:0] cfg_we;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      // Out-of-range channel numbers match no instance and are dropped.
      assign cfg_we[c] = cfg_wr && (int'(cfg_chan) == c);

      bucket_timer_chan #(
         .PERIOD_WIDTH   (PERIOD_WIDTH),
         .DEFAULT_PERIOD (DEFAULT_PERIOD),
         .NUM_BUCKETS    (NUM_BUCKETS),
         .BUCKET_BITS    (BUCKET_BITS)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .enable      (chan_enable[c]),
         .cfg_we      (cfg_we[c]),
         .cfg_period  (cfg_period),
         .update_ack  (update_ack[c]),
         .overrun_clr (overrun_clr[c]),
         .update_req  (update_req[c]),
         .bucket_idx  (bucket_idx[c*BUCKET_BITS +: BUCKET_BITS]),
`ifdef BUCKET_TIMER_MISSED_CNT_EN
         .missed_cnt  (missed_cnt[c*MISSED_CNT_WIDTH +: MISSED_CNT_WIDTH]),
`endif
         .overrun     (overrun[c])
      );
   end

endmodule

// File: tb/tb_bucket_timer.sv
// Directed self-checking bench for bucket_timer with hand-computed expectations.
module tb_bucket_timer;

   localparam int NCH = 4;
   localparam int PW  = 32;
   localparam int BB  = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [NCH-1:0]  chan_enable;
   logic            cfg_wr;
   logic [1:0]      cfg_chan;
   logic [PW-1:0]   cfg_period;
   logic [NCH-1:0]  update_req;
   logic [NCH-1:0]  update_ack;
   logic [NCH*BB-1:0] bucket_idx;
   logic [NCH-1:0]  overrun;
   logic [NCH-1:0]  overrun_clr;
`ifdef BUCKET_TIMER_MISSED_CNT_EN
   logic [NCH*8-1:0] missed_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bucket_timer dut (
      .clk         (clk),
      .reset       (reset),
      .chan_enable (chan_enable),
      .cfg_wr      (cfg_wr),
      .cfg_chan    (cfg_chan),
      .cfg_period  (cfg_period),
      .update_req  (update_req),
      .update_ack  (update_ack),
      .bucket_idx  (bucket_idx),
      .overrun     (overrun),
`ifdef BUCKET_TIMER_MISSED_CNT_EN
      .missed_cnt  (missed_cnt),
`endif
      .overrun_clr (overrun_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int c, input logic [PW-1:0] p);
      cfg_wr     = 1'b1;
      cfg_chan   = 2'(c);
      cfg_period = p;
      tick();
      cfg_wr     = 1'b0;
   endtask

   function automatic logic [31:0] bidx(input int c);
      return 32'(bucket_idx[c*BB +: BB]);
   endfunction

`ifdef BUCKET_TIMER_MISSED_CNT_EN
   function automatic logic [31:0] mcnt(input int c);
      return 32'(missed_cnt[c*8 +: 8]);
   endfunction
`endif

   initial begin
      reset       = 1'b1;
      chan_enable = '0;
      cfg_wr      = 1'b0;
      cfg_chan    = '0;
      cfg_period  = '0;
      update_ack  = '0;
      overrun_clr = '0;
      tick(2);
      reset = 1'b0;
      check("rst_req", 32'(update_req), 0);
      check("rst_bidx", 32'(bucket_idx), 0);
      check("rst_ovr", 32'(overrun), 0);
`ifdef BUCKET_TIMER_MISSED_CNT_EN
      check("rst_missed", missed_cnt, 0);
`endif

      // Channel 0: P=4, ack tied high -> one-cycle pulses every 4 cycles.
      chan_enable   = 4'b0001;
      update_ack[0] = 1'b1;
      cfg(0, 4);
      tick(4);
      check("t1_quiet", 32'(update_req[0]), 0);
      tick();
      check("t1_first", 32'(update_req[0]), 1);
      check("t1_b0", bidx(0), 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("t1_low", 32'(update_req[0]), 0);
         check("t1_bidx", bidx(0), 32'(k % 8));
         tick(3);
         check("t1_pulse", 32'(update_req[0]), 1);
      end
      chan_enable[0] = 1'b0;
      tick();
      check("t1_end_req", 32'(update_req[0]), 0);
      check("t1_end_bidx", bidx(0), 1);
      update_ack[0] = 1'b0;

      // Channel 1: P=4, ack 6 cycles late -> overrun per request.
      chan_enable = 4'b0010;
      cfg(1, 4);
      tick(5);
      check("t2_req", 32'(update_req[1]), 1);
      tick(3);
      check("t2_ovr_pre", 32'(overrun[1]), 0);
      tick();
      check("t2_ovr", 32'(overrun[1]), 1);
`ifdef BUCKET_TIMER_MISSED_CNT_EN
      check("t2_missed1", mcnt(1), 1);
`endif
      tick(2);
      update_ack[1] = 1'b1;
      tick();
      update_ack[1] = 1'b0;
      check("t2_ack1_req", 32'(update_req[1]), 0);
      check("t2_ack1_bidx", bidx(1), 1);
      tick(5);
      check("t2_req2", 32'(update_req[1]), 1);
`ifdef BUCKET_TIMER_MISSED_CNT_EN
      check("t2_missed2", mcnt(1), 2);
`endif
      tick(2);
      update_ack[1] = 1'b1;
      tick();
      update_ack[1] = 1'b0;
      check("t2_ack2_req", 32'(update_req[1]), 0);
      check("t2_ack2_bidx", bidx(1), 2);
      check("t2_ovr_sticky", 32'(overrun[1]), 1);
      overrun_clr[1] = 1'b1;
      tick();
      overrun_clr[1] = 1'b0;
      check("t2_clr_ovr", 32'(overrun[1]), 0);
`ifdef BUCKET_TIMER_MISSED_CNT_EN
      check("t2_clr_missed", mcnt(1), 0);
`endif
      check("t2_req3", 32'(update_req[1]), 1);

      // Disabled channel keeps its pending request and generates no events.
      chan_enable[1] = 1'b0;
      tick(100);
      check("t5_hold_req", 32'(update_req[1]), 1);
      check("t5_hold_ovr", 32'(overrun[1]), 0);
      update_ack[1] = 1'b1;
      tick();
      update_ack[1] = 1'b0;
      check("t5_ack_req", 32'(update_req[1]), 0);
      check("t5_ack_bidx", bidx(1), 3);
      chan_enable[1] = 1'b1;
      tick(4);
      check("t5_resume_quiet", 32'(update_req[1]), 0);
      tick();
      check("t5_resume_req", 32'(update_req[1]), 1);
      update_ack[1] = 1'b1;
      tick();
      update_ack[1]  = 1'b0;
      chan_enable[1] = 1'b0;
      check("t5_resume_bidx", bidx(1), 4);

      // Channel 3: period rewrite mid-count and at the terminal count.
      chan_enable = 4'b1000;
      cfg(3, 5);
      tick(3);
      cfg(3, 10);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_quiet", 32'(update_req[3]), 0);
      end
      tick();
      check("t4_req", 32'(update_req[3]), 1);
      update_ack[3] = 1'b1;
      tick();
      update_ack[3] = 1'b0;
      check("t4_ack_bidx", bidx(3), 1);
      tick(7);
      cfg(3, 10);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_term_quiet", 32'(update_req[3]), 0);
      end
      tick();
      check("t4_term_req", 32'(update_req[3]), 1);
      update_ack[3] = 1'b1;
      tick();
      update_ack[3] = 1'b0;
      cfg(3, 0);
      tick(100);
      check("t5_p0_quiet", 32'(update_req[3]), 0);
      check("t5_p0_bidx", bidx(3), 2);
      chan_enable = '0;

      // Channel 2: P=3, ack coincides with terminal, then reset mid-request.
      chan_enable = 4'b0100;
      cfg(2, 3);
      tick(4);
      check("t3_req", 32'(update_req[2]), 1);
      tick(2);
      update_ack[2] = 1'b1;
      tick();
      check("t3_coin_req", 32'(update_req[2]), 1);
      check("t3_coin_bidx", bidx(2), 1);
      check("t3_coin_ovr", 32'(overrun[2]), 0);
      tick();
      check("t3_idle", 32'(update_req[2]), 0);
      check("t3_bidx2", bidx(2), 2);
      tick(9);
      check("t3_bidx5", bidx(2), 5);
      update_ack[2] = 1'b0;
      tick(2);
      check("t6_pre_req", 32'(update_req[2]), 1);
      check("t6_pre_bidx", bidx(2), 5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rst_req", 32'(update_req[2]), 0);
      check("t6_rst_bidx", bidx(2), 0);
      tick(20);
      check("t6_default_period", 32'(update_req), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
